// File: rtl/ram_32768x3_if.sv
// Board memory access bus: controller-side address/data/write strobe, memory-side read data and busy.
interface ram_32768x3_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q;
  logic                  busy;

  // Player/RAM-update controller side
  modport master (
    output address,
    output data,
    output wren,
    input  q,
    input  busy
  );

  // Memory side
  modport slave (
    input  address,
    input  data,
    input  wren,
    output q,
    output busy
  );
endinterface

// File: rtl/ram_32768x3.sv
// Single-port synchronous playfield memory, one colour code per cell,
// address = {X[7:0], Y[6:0]}. A reset launches a hardware sweep that writes
// CLEAR_VALUE to every cell. busy stays high until the sweep completes, and
// user accesses are ignored while busy is high.
module ram_32768x3 #(
  parameter int unsigned           ADDR_WIDTH  = 15,
  parameter int unsigned           DATA_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  ram_32768x3_if.slave       bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  // Select the single write port source: clear sweep, user write, or nothing
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = bus.address;
    mem_wdata_c = bus.data;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_ptr;
        mem_wdata_c = CLEAR_VALUE;
      end else if (bus.wren) begin
        mem_we_c = 1'b1;
      end
    end
  end

  // Memory array write port, kept reset-free so it maps onto block RAM
  always_ff @(posedge CLOCK_50) begin
    if (mem_we_c) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

  // Control FSM with registered read data, busy and clear pointer
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      bus.q    <= '0;
      bus.busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          bus.q   <= '0;
          clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
          if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          // Read-during-write returns the new data
          if (bus.wren) begin
            bus.q <= bus.data;
          end else begin
            bus.q <= mem[bus.address];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_32768x3.sv
// Randomized self-checking bench for ram_32768x3 with a flat-array reference model.
module tb_ram_32768x3;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 3;
  localparam int unsigned DEPTH = 32768;
  localparam int          BUSY_LIMIT = 40000;

  logic CLOCK_50;
  logic reset;

  ram_32768x3_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_32768x3 dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [DW-1:0] model [DEPTH];
  int n_checks;
  int n_fail;

  // Advance one rising edge, then settle before driving or sampling
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Present one IDLE operation for one edge; return what the model expects on q
  task automatic do_op(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                       output logic [DW-1:0] exp_q);
    bus.address = a;
    bus.wren    = we;
    bus.data    = d;
    if (we) begin
      model[a] = d;
      exp_q    = d;
    end else begin
      exp_q = model[a];
    end
    step();
    bus.wren = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    do_op(a, 1'b0, '0, e);
    n_checks++;
    if (bus.q !== e) begin
      n_fail++;
      $display("FAIL %s addr=%h q=%0d expected=%0d", name, a, bus.q, e);
    end
  endtask

  task automatic check_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    do_op(a, 1'b1, d, e);
    n_checks++;
    if (bus.q !== e) begin
      n_fail++;
      $display("FAIL %s addr=%h q=%0d expected=%0d", name, a, bus.q, e);
    end
  endtask

  // Count edges from now until busy drops; returns BUSY_LIMIT+1 on timeout
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n <= BUSY_LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int n;
    pulse_reset();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b q=%0d expected busy=1 q=0", bus.busy, bus.q);
    end
    count_busy(n);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL busy_len edges=%0d expected=%0d", n, DEPTH);
    end
    check_read("clear_0000", 15'h0000);
    check_read("clear_4000", 15'h4000);
    check_read("clear_7fff", 15'h7FFF);
  endtask

  task automatic test_corner_write();
    check_write("wr_7fff", 15'h7FFF, 3'b101);
    check_read("rd_7fff", 15'h7FFF);
    check_read("rd_7f7f_alias", 15'h7F7F);
  endtask

  task automatic test_back_to_back();
    check_write("b2b_wr1", 15'h0001, 3'd1);
    check_write("b2b_wr2", 15'h0002, 3'd2);
    check_write("b2b_wr3", 15'h0003, 3'd3);
    check_read("b2b_rd3", 15'h0003);
    check_read("b2b_rd2", 15'h0002);
    check_read("b2b_rd1", 15'h0001);
  endtask

  task automatic test_rdw();
    check_write("rdw_prev", 15'h0500, 3'd2);
    check_write("rdw_new", 15'h0500, 3'd4);
    check_read("rdw_after", 15'h0500);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    for (int i = 0; i < 400; i++) begin
      // Mostly a small hot region so reads hit recent writes
      if ($urandom_range(0, 3) == 0) a = AW'($urandom);
      else                           a = AW'($urandom_range(0, 15)) | 15'h2A00;
      d  = DW'($urandom);
      we = ($urandom_range(0, 1) == 1);
      if (we) check_write("rand_wr", a, d);
      else    check_read("rand_rd", a);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    check_write("pre_clear_wr", 15'h1234, 3'd6);
    pulse_reset();
    for (int i = 0; i < 99; i++) step();
    bus.address = 15'h1234;
    bus.data    = 3'd7;
    bus.wren    = 1'b1;
    step();
    bus.wren = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.q !== 3'd0) begin
      n_fail++;
      $display("FAIL ignored_wr busy=%b q=%0d expected busy=1 q=0", bus.busy, bus.q);
    end
    for (int i = 0; i < 900; i++) begin
      bus.address = AW'($urandom);
      bus.data    = DW'($urandom);
      bus.wren    = ($urandom_range(0, 1) == 1);
      step();
    end
    bus.wren = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.q !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_sweep_state busy=%b q=%0d expected busy=1 q=0", bus.busy, bus.q);
    end
    pulse_reset();
    count_busy(n);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL restart_busy_len edges=%0d expected=%0d", n, DEPTH);
    end
    check_read("after_clear_1234", 15'h1234);
    check_read("after_clear_7fff", 15'h7FFF);
    check_read("after_clear_0500", 15'h0500);
    for (int i = 0; i < 40; i++) check_read("after_clear_rand", AW'($urandom));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    bus.wren    = 1'b0;
    model_clear();
    step();
    test_reset();
    test_corner_write();
    test_back_to_back();
    test_rdw();
    test_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
